addsub_chunked: RTL and testbench

ADDSUB_CHUNKED -- requirements
Module: addsub_chunked

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_slice.sv | 20 ++
 rtl/addsub_chunked.sv | 128 ++++++++++++
 tb/tb_addsub_chunked.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and chunk-count helper for addsub_chunked
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational CHUNK-bit adder slice with carry and MSB taps for overflow
module addsub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb,
  output logic             s_msb
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign a_msb = a[CHUNK-1];
  assign b_msb = b[CHUNK-1];
  assign s_msb = s[CHUNK-1];

endmodule

// File: rtl/addsub_chunked.sv
// rtl/addsub_chunked.sv - multi-cycle add/subtract, CHUNK bits per clock
// Optional accumulator feedback port acc enabled by ADDSUB_CHUNKED_ACC_EN.
module addsub_chunked
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_CHUNKED_ACC_EN
  input  logic             acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = $clog2(NCHUNK + 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK <= 0) begin : g_bad_params
    $error("addsub_chunked: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, res_r, res_next, a_sel;
  logic             c_r, ovf_r;
  logic             last;

  logic [CHUNK-1:0] s_w;
  logic             cout_w, a_msb_w, b_msb_w, s_msb_w;

`ifdef ADDSUB_CHUNKED_ACC_EN
  assign a_sel = acc ? sum : a;
`else
  assign a_sel = a;
`endif

  // cnt reaches NCHUNK one cycle after the final slice; that cycle publishes the result
  assign last = (cnt == CW'(NCHUNK));

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_r[CHUNK-1:0]),
    .b     (b_r[CHUNK-1:0]),
    .cin   (c_r),
    .s     (s_w),
    .cout  (cout_w),
    .a_msb (a_msb_w),
    .b_msb (b_msb_w),
    .s_msb (s_msb_w)
  );

  if (NCHUNK == 1) begin : g_one
    assign res_next = s_w;
  end else begin : g_many
    assign res_next = {s_w, res_r[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN:  if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c_r   <= 1'b0;
      ovf_r <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a_sel;
          b_r <= sub ? ~b : b;
          c_r <= sub;
          cnt <= '0;
        end
        RUN: if (!last) begin
          // operands shift down so the slice always sees the next slice at bit 0
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          res_r <= res_next;
          c_r   <= cout_w;
          ovf_r <= (a_msb_w == b_msb_w) && (s_msb_w != a_msb_w);
          cnt   <= cnt + CW'(1);
        end else begin
          sum   <= res_r;
          carry <= c_r;
          ovf   <= ovf_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
// tb/tb_addsub_chunked.sv - scoreboard bench for addsub_chunked (32/8 and 16/4 instances)
module tb_addsub_chunked;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          cap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic        iv0 = 0, or0 = 1, sb0 = 0, acc0 = 0;
  logic [31:0] a0 = 0, b0 = 0;
  logic        ir0, ov0, c0, f0;
  logic [31:0] sum0;

  logic        iv1 = 0, or1 = 1, sb1 = 0;
  logic [15:0] a1 = 0, b1 = 0;
  logic        ir1, ov1, c1, f1;
  logic [15:0] sum1;

  logic ov_p0 = 0, ov_p1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_chunked #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .a(a0), .b(b0), .sub(sb0),
`ifdef ADDSUB_CHUNKED_ACC_EN
    .acc(acc0),
`endif
    .out_valid(ov0), .out_ready(or0), .sum(sum0), .carry(c0), .ovf(f0)
  );

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .sub(sb1),
`ifdef ADDSUB_CHUNKED_ACC_EN
    .acc(1'b0),
`endif
    .out_valid(ov1), .out_ready(or1), .sum(sum1), .carry(c1), .ovf(f1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) ov_p0 = 1'b0;
    else begin
      if (ov0 && !ov_p0) begin
        if (q0.size() == 0) chk("u32_unexpected_valid", 32'd1, 32'd0);
        else chk("u32_latency", cyc - q0[0].cap, 32'd5);
      end
      if (ov0 && !or0 && q0.size() > 0) chk("u32_hold_sum", sum0, q0[0].s);
      if (ov0 && or0 && q0.size() > 0) begin
        chk("u32_sum", sum0, q0[0].s);
        chk("u32_carry", {31'd0, c0}, {31'd0, q0[0].c});
        chk("u32_ovf", {31'd0, f0}, {31'd0, q0[0].o});
        void'(q0.pop_front());
      end
      ov_p0 = ov0;
    end
  end

  always @(negedge clk) begin
    if (rst) ov_p1 = 1'b0;
    else begin
      if (ov1 && !ov_p1) begin
        if (q1.size() == 0) chk("u16_unexpected_valid", 32'd1, 32'd0);
        else chk("u16_latency", cyc - q1[0].cap, 32'd5);
      end
      if (ov1 && or1 && q1.size() > 0) begin
        chk("u16_sum", {16'd0, sum1}, q1[0].s);
        chk("u16_carry", {31'd0, c1}, {31'd0, q1[0].c});
        chk("u16_ovf", {31'd0, f1}, {31'd0, q1[0].o});
        void'(q1.pop_front());
      end
      ov_p1 = ov1;
    end
  end

  task automatic req(input int sel, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input logic acc,
                     input logic [31:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (((sel == 0) ? ir0 : ir1) !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (sel == 0) begin
      iv0 = 1; a0 = a; b0 = b; sb0 = sub; acc0 = acc;
    end else begin
      iv1 = 1; a1 = a[15:0]; b1 = b[15:0]; sb1 = sub;
    end
    @(posedge clk);
    #1;
    iv0 = 0; iv1 = 0; acc0 = 0;
    e.s = es; e.c = ec; e.o = eo; e.cap = cyc;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov0}, 32'd0);
    chk("rst_in_ready", {31'd0, ir0}, 32'd1);
    chk("rst_sum", sum0, 32'd0);
    chk("rst_flags", {30'd0, c0, f0}, 32'd0);
    rst = 0;

    req(0, 32'h00000001, 32'h00000000, 0, 0, 32'h00000001, 0, 0);
    req(0, 32'h0000ffff, 32'h00000001, 0, 0, 32'h00010000, 0, 0);
    req(0, 32'h00010000, 32'h00000001, 1, 0, 32'h0000ffff, 1, 0);
    req(0, 32'hffffffff, 32'hffffffff, 0, 0, 32'hfffffffe, 1, 0);
    req(0, 32'h7fffffff, 32'h00000001, 0, 0, 32'h80000000, 0, 1);
    req(0, 32'h00000002, 32'h00000002, 1, 0, 32'h00000000, 1, 0);
    wait_idle();

    or0 = 0;
    req(0, 32'h12345678, 32'h11111111, 0, 0, 32'h23456789, 0, 0);
    for (int i = 0; i < 60 && !ov0; i++) @(negedge clk);
    chk("bp_reached_done", {31'd0, ov0}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv0 = ~iv0; a0 = 32'h1000 + i; b0 = 32'h77 * i; sb0 = i[0];
      chk("bp_in_ready", {31'd0, ir0}, 32'd0);
      chk("bp_out_valid", {31'd0, ov0}, 32'd1);
    end
    @(negedge clk);
    iv0 = 0; or0 = 1;
    @(negedge clk);
    chk("bp_single_hs", {30'd0, ov0, ir0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_no_capture", {30'd0, ov0, ir0}, 32'd1);

    req(0, 32'h80000000, 32'h00000001, 1, 0, 32'h7fffffff, 1, 1);
    wait_idle();

    req(0, 32'h0f0f0f0f, 32'h01010101, 0, 0, 32'h10101010, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrun_rst_valid", {31'd0, ov0}, 32'd0);
    chk("midrun_rst_sum", sum0, 32'd0);
    chk("midrun_rst_flags", {30'd0, c0, f0}, 32'd0);
    q0.delete();
    @(negedge clk);
    rst = 0;
    chk("midrun_rst_in_ready", {31'd0, ir0}, 32'd1);
    req(0, 32'h00000100, 32'h000000ff, 0, 0, 32'h000001ff, 0, 0);
    wait_idle();

`ifdef ADDSUB_CHUNKED_ACC_EN
    req(0, 32'h00000005, 32'h00000003, 0, 0, 32'h00000008, 0, 0);
    req(0, 32'h0000dead, 32'h00000002, 1, 1, 32'h00000006, 1, 0);
    wait_idle();
`endif

    req(1, 32'h0001, 32'h0000, 0, 0, 32'h0001, 0, 0);
    req(1, 32'hffff, 32'hffff, 0, 0, 32'hfffe, 1, 0);
    req(1, 32'h7fff, 32'h0001, 0, 0, 32'h8000, 0, 1);
    req(1, 32'h0002, 32'h0002, 1, 0, 32'h0000, 1, 0);
    wait_idle();

    chk("drain", q0.size() + q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
